// File: rtl/byte_io_hub.sv
// rtl/byte_io_hub.sv - I/O register map, input/step synchronisers and run/single-step control for the Byte-Computer core
module byte_io_hub #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int N_OUT   = 4,
    parameter int IO_BASE = 28,
    localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              step_mode,
    input  logic              step_btn,
    input  logic [DATA_W-1:0] pin_in,
    input  logic [SEL_W-1:0]  pin_sel,
    output logic [DATA_W-1:0] pin_out,
    output logic              core_start,
    input  logic              core_halt,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic [1:0]        state,
    output logic [7:0]        wr_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_e;

    // Address decode is done in 32-bit space so map entries that do not fit in ADDR_W never match.
    localparam logic [31:0] BASE_U = 32'(IO_BASE);
    localparam logic [31:0] END_U  = 32'(IO_BASE + N_OUT);
    localparam logic [31:0] CNT_U  = 32'(IO_BASE + N_OUT + 1);
    localparam logic [31:0] NOUT_U = 32'(N_OUT);

    state_e              state_q, state_d;
    logic                core_start_q, core_start_d;
    logic [DATA_W-1:0]   out_reg_q [N_OUT];
    logic [DATA_W-1:0]   out_reg_d [N_OUT];
    logic [7:0]          wr_count_q, wr_count_d;
    logic [DATA_W-1:0]   pin_s1_q, pin_s1_d;
    logic [DATA_W-1:0]   pin_sync_q, pin_sync_d;
    logic                step_s1_q, step_s1_d;
    logic                step_s2_q, step_s2_d;
    logic                step_prev_q, step_prev_d;

    logic [31:0]         addr_ext;
    logic                wr_hit;
    logic [SEL_W-1:0]    wr_idx;
    logic                step_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            core_start_q <= 1'b0;
            wr_count_q   <= '0;
            pin_s1_q     <= '0;
            pin_sync_q   <= '0;
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            step_prev_q  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) out_reg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            wr_count_q   <= wr_count_d;
            pin_s1_q     <= pin_s1_d;
            pin_sync_q   <= pin_sync_d;
            step_s1_q    <= step_s1_d;
            step_s2_q    <= step_s2_d;
            step_prev_q  <= step_prev_d;
            for (int i = 0; i < N_OUT; i++) out_reg_q[i] <= out_reg_d[i];
        end
    end

    always_comb begin
        pin_s1_d    = pin_in;
        pin_sync_d  = pin_s1_q;
        step_s1_d   = step_btn;
        step_s2_d   = step_s1_q;
        step_prev_d = step_s2_q;
    end

    always_comb begin
        addr_ext   = 32'(core_addr);
        wr_hit     = core_we && (addr_ext >= BASE_U) && (addr_ext < END_U);
        wr_idx     = SEL_W'(addr_ext - BASE_U);
        wr_count_d = wr_count_q;
        for (int i = 0; i < N_OUT; i++) out_reg_d[i] = out_reg_q[i];
        if (wr_hit) begin
            out_reg_d[wr_idx] = core_wdata;
            if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_comb begin
        step_edge = step_s2_q & ~step_prev_q;
        state_d   = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_en) state_d = step_mode ? S_STEP : S_RUN;
            end
            S_RUN, S_STEP: begin
                if (core_halt)    state_d = S_HALTED;
                else if (!run_en) state_d = S_IDLE;
            end
            S_HALTED: begin
                if (!run_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A step pulse needs STEP both before and after the edge; edges arriving elsewhere are dropped.
        core_start_d = (state_d == S_RUN) ||
                       ((state_q == S_STEP) && (state_d == S_STEP) && step_edge);
    end

    always_comb begin
        if (addr_ext == END_U)      core_rdata = DATA_W'(state_q);
        else if (addr_ext == CNT_U) core_rdata = DATA_W'(wr_count_q);
        else                        core_rdata = pin_sync_q;
        if (32'(pin_sel) < NOUT_U)  pin_out = out_reg_q[pin_sel];
        else                        pin_out = '0;
    end

    assign core_start = core_start_q;
    assign state      = state_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_byte_io_hub.sv
// tb/tb_byte_io_hub.sv - directed vector bench for byte_io_hub
module tb_byte_io_hub;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en, step_mode, step_btn;
    logic [7:0] pin_in;
    logic [1:0] pin_sel;
    logic [7:0] pin_out;
    logic       core_start, core_halt, core_we;
    logic [5:0] core_addr;
    logic [7:0] core_wdata, core_rdata;
    logic [1:0] state;
    logic [7:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    byte_io_hub #(.DATA_W(8), .ADDR_W(6), .N_OUT(4), .IO_BASE(28)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .step_mode(step_mode), .step_btn(step_btn),
        .pin_in(pin_in), .pin_sel(pin_sel), .pin_out(pin_out), .core_start(core_start),
        .core_halt(core_halt), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .state(state), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [1:0] sel;
        logic [7:0] exp_out;
        logic [7:0] exp_rd;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd28, 8'hA5, 2'd0, 8'hA5, 8'h00, 8'd1};
        vecs[1] = '{1'b1, 6'd31, 8'h3C, 2'd3, 8'h3C, 8'h00, 8'd2};
        vecs[2] = '{1'b1, 6'd27, 8'hFF, 2'd0, 8'hA5, 8'h00, 8'd2};
        vecs[3] = '{1'b0, 6'd33, 8'h00, 2'd3, 8'h3C, 8'h02, 8'd2};
        vecs[4] = '{1'b0, 6'd32, 8'h00, 2'd1, 8'h00, 8'h00, 8'd2};
        vecs[5] = '{1'b1, 6'd29, 8'h11, 2'd1, 8'h11, 8'h00, 8'd3};
        vecs[6] = '{1'b1, 6'd32, 8'h77, 2'd2, 8'h00, 8'h00, 8'd3};
        vecs[7] = '{1'b0, 6'd33, 8'h00, 2'd2, 8'h00, 8'h03, 8'd3};
        vecs[8] = '{1'b1, 6'd30, 8'hC3, 2'd2, 8'hC3, 8'h00, 8'd4};
        vecs[9] = '{1'b0, 6'd33, 8'h00, 2'd0, 8'hA5, 8'h04, 8'd4};

        rst = 1'b1; run_en = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
        pin_in = 8'h00; pin_sel = 2'd0; core_halt = 1'b0; core_we = 1'b0;
        core_addr = 6'd0; core_wdata = 8'h00;
        repeat (3) tick();
        check("rst_state", state, 2'b00);
        check("rst_start", core_start, 1'b0);
        check("rst_count", wr_count, 8'd0);
        check("rst_pin_out", pin_out, 8'h00);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            core_we = vecs[i].we; core_addr = vecs[i].addr;
            core_wdata = vecs[i].wdata; pin_sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d_pin_out", i), pin_out, vecs[i].exp_out);
            check($sformatf("vec%0d_rdata", i), core_rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_count", i), wr_count, vecs[i].exp_cnt);
        end
        core_we = 1'b0;

        core_addr = 6'd0;
        pin_in = 8'h5A;
        tick();
        check("pin_sync_1edge", core_rdata, 8'h00);
        tick();
        check("pin_sync_2edge", core_rdata, 8'h5A);

        run_en = 1'b1; step_mode = 1'b0; core_addr = 6'd32;
        #1;
        check("idle_start", core_start, 1'b0);
        tick();
        check("run_state", state, 2'b01);
        check("run_start", core_start, 1'b1);
        check("run_rd_state", core_rdata, 8'h01);
        step_mode = 1'b1;
        tick();
        check("run_ignore_mode", state, 2'b01);
        core_halt = 1'b1;
        tick();
        check("halt_state", state, 2'b11);
        check("halt_start", core_start, 1'b0);
        core_halt = 1'b0;
        tick();
        check("halt_hold", state, 2'b11);
        run_en = 1'b0;
        tick();
        check("halt_to_idle", state, 2'b00);

        run_en = 1'b1; step_mode = 1'b1;
        tick();
        check("step_state", state, 2'b10);
        check("step_idle_start", core_start, 1'b0);
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                check($sformatf("press%0d_k%0d", p, k), core_start, (k == 3));
                if (k == 5) step_btn = 1'b0;
            end
        end

        core_halt = 1'b1;
        tick();
        check("step_halt_state", state, 2'b11);
        core_halt = 1'b0;
        step_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("halted_press_k%0d", k), core_start, 1'b0);
            if (k == 5) step_btn = 1'b0;
        end
        check("halted_press_state", state, 2'b11);
        run_en = 1'b0;
        tick();

        core_we = 1'b1; core_addr = 6'd29;
        for (int n = 1; n <= 300; n++) begin
            core_wdata = 8'(n);
            tick();
            if (n == 250) check("sat_254", wr_count, 8'd254);
            if (n == 251) check("sat_255", wr_count, 8'd255);
        end
        check("sat_final", wr_count, 8'd255);
        core_we = 1'b0; core_addr = 6'd33;
        #1;
        check("sat_read", core_rdata, 8'hFF);

        pin_sel = 2'd0; run_en = 1'b1; step_mode = 1'b0;
        tick();
        check("pre_rst_start", core_start, 1'b1);
        check("pre_rst_pin_out", pin_out, 8'hA5);
        #2;
        rst = 1'b1;
        #1;
        check("async_start", core_start, 1'b0);
        check("async_state", state, 2'b00);
        check("async_count", wr_count, 8'd0);
        check("async_pin_out", pin_out, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
